// File: rtl/rom_access_ctrl.sv
// rtl/rom_access_ctrl.sv - Z80 / debug-port read sequencer for the two 8 KB pROM banks
// Optional debug read port guarded by macro ROM_DBG_EN (absent in the default build).
module rom_access_ctrl #(
    parameter int ROM_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_iorq_n,
    output logic        cpu_wait_n,
    output logic        rom0_ce,
    output logic        rom1_ce,
    output logic        rom_oce,
    output logic        rom_iorq,
    output logic [12:0] rom_ad,
    input  logic [7:0]  rom_data,
    input  logic        dbg_req,
    input  logic [13:0] dbg_addr,
    output logic [7:0]  dbg_rdata,
    output logic        dbg_ack
);

    typedef enum logic [1:0] {IDLE, CPU_RD, CPU_HOLD, DBG_RD} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             bank;
    logic             cpu_rom_rd;
    logic             dbg_start;

    assign cpu_rom_rd = !cpu_mreq_n && !cpu_rd_n && (cpu_addr[15:14] == 2'b00);

`ifdef ROM_DBG_EN
    // Blocking restart during the ack cycle keeps a still-high request from retriggering.
    assign dbg_start = dbg_req && cpu_mreq_n && cpu_iorq_n && !dbg_ack;
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_req, dbg_addr, rom_data};
    assign dbg_start  = 1'b0;
    assign dbg_rdata  = 8'h00;
    assign dbg_ack    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bank   <= 1'b0;
            rom_ad <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == CPU_RD) begin
                cnt    <= CNT_LOAD;
                bank   <= cpu_addr[13];
                rom_ad <= cpu_addr[12:0];
            end else if (state == IDLE && state_next == DBG_RD) begin
                cnt    <= CNT_LOAD;
                bank   <= dbg_addr[13];
                rom_ad <= dbg_addr[12:0];
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef ROM_DBG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata <= 8'h00;
            dbg_ack   <= 1'b0;
        end else begin
            dbg_ack <= 1'b0;
            if (state == DBG_RD && cnt == '0) begin
                dbg_rdata <= rom_data;
                dbg_ack   <= 1'b1;
            end
        end
    end
`endif

    // CPU_RD lasts ROM_LAT-1 clocks so that, with the IDLE decode cycle, WAIT spans ROM_LAT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_rom_rd)
                    state_next = CPU_RD;
                else if (dbg_start)
                    state_next = DBG_RD;
            end
            CPU_RD: begin
                if (!cpu_rom_rd)
                    state_next = IDLE;
                else if (cnt <= CNT_W'(1))
                    state_next = CPU_HOLD;
            end
            CPU_HOLD: begin
                if (!cpu_rom_rd)
                    state_next = IDLE;
            end
`ifdef ROM_DBG_EN
            DBG_RD: begin
                if (cnt == '0)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom0_ce    = 1'b0;
        rom1_ce    = 1'b0;
        rom_oce    = 1'b0;
        rom_iorq   = !cpu_iorq_n && (state != DBG_RD);
        cpu_wait_n = reset || !(cpu_rom_rd && (state != CPU_HOLD));
        if (state != IDLE) begin
            rom0_ce = !bank;
            rom1_ce = bank;
            rom_oce = 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb/tb_rom_access_ctrl.sv - directed self-checking bench for rom_access_ctrl
module tb_rom_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_iorq_n;
    logic        cpu_wait_n;
    logic        rom0_ce;
    logic        rom1_ce;
    logic        rom_oce;
    logic        rom_iorq;
    logic [12:0] rom_ad;
    logic [7:0]  rom_data;
    logic        dbg_req;
    logic [13:0] dbg_addr;
    logic [7:0]  dbg_rdata;
    logic        dbg_ack;

    int checks   = 0;
    int failures = 0;
    int wait_cnt;

    always #5 clk = ~clk;

    rom_access_ctrl #(.ROM_LAT(2), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_wait_n (cpu_wait_n),
        .rom0_ce    (rom0_ce),
        .rom1_ce    (rom1_ce),
        .rom_oce    (rom_oce),
        .rom_iorq   (rom_iorq),
        .rom_ad     (rom_ad),
        .rom_data   (rom_data),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_iorq_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_addr   = a;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        cpu_addr = 16'h0000;
        cpu_idle();
        rom_data = 8'h00;
        dbg_req  = 1'b0;
        dbg_addr = 14'h0000;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_wait_n", cpu_wait_n, 1);
        check("rst_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        check("rst_iorq", rom_iorq, 0);
        check("rst_ad", rom_ad, 0);
        check("rst_dbg", {dbg_ack, dbg_rdata}, 0);

        // CPU read bank 0: wait low for exactly two cycles
        cpu_read(16'h0123);
        #1;
        check("rd0_wait_c1", cpu_wait_n, 0);
        check("rd0_ce_c1", rom0_ce, 0);
        tick();
        check("rd0_wait_c2", cpu_wait_n, 0);
        check("rd0_ce", {rom0_ce, rom1_ce, rom_oce}, 3'b101);
        check("rd0_ad", rom_ad, 13'h0123);
        tick();
        check("rd0_wait_hold", cpu_wait_n, 1);
        check("rd0_ce_hold", {rom0_ce, rom_oce}, 2'b11);
        cpu_idle();
        #1;
        check("rd0_ce_before_edge", rom0_ce, 1);
        tick();
        check("rd0_ce_drop", {rom0_ce, rom1_ce, rom_oce}, 0);

        // CPU read bank 1
        cpu_read(16'h2ABC);
        tick();
        check("rd1_ce", {rom0_ce, rom1_ce, rom_oce}, 3'b011);
        check("rd1_ad", rom_ad, 13'h0ABC);
        tick();
        check("rd1_wait_hold", cpu_wait_n, 1);
        cpu_idle();
        tick();

        // Write and I/O into ROM space, and a read above ROM
        cpu_addr = 16'h0010;
        cpu_mreq_n = 1'b0;
        #1;
        check("wr_wait", cpu_wait_n, 1);
        tick();
        check("wr_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        cpu_idle();
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        #1;
        check("io_iorq", rom_iorq, 1);
        check("io_wait", cpu_wait_n, 1);
        tick();
        check("io_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        cpu_idle();
        cpu_read(16'h4000);
        #1;
        check("hi_wait", cpu_wait_n, 1);
        tick();
        check("hi_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        cpu_idle();
        tick();

        // Abort during CPU_RD
        cpu_read(16'h1000);
        tick();
        check("abort_in_rd", rom0_ce, 1);
        cpu_idle();
        tick();
        check("abort_ce", {rom0_ce, rom1_ce, rom_oce}, 0);

        // Reset in CPU_RD
        cpu_read(16'h3000);
        tick();
        check("rstrd_ce_before", rom1_ce, 1);
        reset = 1'b1;
        tick();
        check("rstrd_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        check("rstrd_wait", cpu_wait_n, 1);
        check("rstrd_ad", rom_ad, 0);
        cpu_idle();
        reset = 1'b0;
        tick();

`ifdef ROM_DBG_EN
        // Debug read of the last ROM byte
        rom_data = 8'h5A;
        dbg_addr = 14'h3FFF;
        dbg_req  = 1'b1;
        tick();
        check("dbg_ce", {rom0_ce, rom1_ce, rom_oce}, 3'b011);
        check("dbg_ad", rom_ad, 13'h1FFF);
        check("dbg_ack_c1", dbg_ack, 0);
        tick();
        check("dbg_ack_c2", dbg_ack, 0);
        tick();
        check("dbg_ack", dbg_ack, 1);
        check("dbg_rdata", dbg_rdata, 8'h5A);
        check("dbg_ce_after", {rom0_ce, rom1_ce, rom_oce}, 0);
        dbg_req = 1'b0;
        tick();
        check("dbg_ack_pulse", dbg_ack, 0);
        check("dbg_no_retrig", rom_oce, 0);

        // CPU read queued behind a debug read
        rom_data = 8'hC3;
        dbg_addr = 14'h0100;
        dbg_req  = 1'b1;
        tick();
        tick();
        cpu_read(16'h0001);
        wait_cnt = 0;
        #1;
        if (!cpu_wait_n) wait_cnt++;
        tick();
        check("q_ack", dbg_ack, 1);
        check("q_rdata", dbg_rdata, 8'hC3);
        dbg_req = 1'b0;
        if (!cpu_wait_n) wait_cnt++;
        tick();
        check("q_cpu_ce", {rom0_ce, rom1_ce, rom_oce}, 3'b101);
        check("q_cpu_ad", rom_ad, 13'h0001);
        for (int i = 0; i < 8 && !cpu_wait_n; i++) begin
            wait_cnt++;
            tick();
        end
        check("q_wait_cycles", wait_cnt, 3);
        check("q_hold_wait", cpu_wait_n, 1);
        cpu_idle();
        tick();
        check("q_ce_drop", rom_oce, 0);
`else
        // Debug port absent: requests are ignored
        dbg_addr = 14'h0000;
        dbg_req  = 1'b1;
        rom_data = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nodbg_ack", dbg_ack, 0);
            check("nodbg_ce", {rom0_ce, rom1_ce, rom_oce}, 0);
        end
        dbg_req = 1'b0;
        check("nodbg_rdata", dbg_rdata, 0);
        cpu_read(16'h0001);
        tick();
        check("nodbg_cpu_ce", rom0_ce, 1);
        tick();
        check("nodbg_cpu_hold", cpu_wait_n, 1);
        cpu_idle();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
